// File: rtl/pool_fmap_collect_pkg.sv
// pool_pkg: constants, state encoding and slot indexing shared by the pooling
// blocks (feature-map collector, pool window mux, max stage).
//   DATA_W   : pixel width
//   MAP_DIM  : feature-map side (6)
//   POOL_DIM : pooling-window grid side (3 for a 6x6 map with 2x2 windows)
//   state_t  : collector state, FILL (accept pixels) / DRAIN (emit windows)
//   idx(r,c) : raster slot index of pixel (r,c) in the packed map
package pool_pkg;

    localparam int DATA_W   = 8;
    localparam int MAP_DIM  = 6;
    localparam int POOL_DIM = 3;
    localparam int NUM_PIX  = MAP_DIM * MAP_DIM;
    localparam int LIN_W    = NUM_PIX * DATA_W;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [5:0] idx(input logic [2:0] r, input logic [2:0] c);
        return 6'(r) * 6'(MAP_DIM) + 6'(c);
    endfunction

endpackage

// File: rtl/pool_fmap_collect_if.sv
// Pixel-in / window-out bundle of the feature-map collector.
//   slave  : collector side (accepts pixels, presents windows)
//   master : producer/consumer side (convolution output + pool stage)
interface pool_fmap_collect_if;
    import pool_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  in_last;
    logic [LIN_W-1:0]      conv_lin;
    logic [1:0]            r_cnt;
    logic [1:0]            c_cnt;
    logic                  win_valid;
    logic                  win_ready;
    logic                  map_done;

    modport slave (
        input  in_valid, in_data, in_last, win_ready,
        output in_ready, conv_lin, r_cnt, c_cnt, win_valid, map_done
    );

    modport master (
        output in_valid, in_data, in_last, win_ready,
        input  in_ready, conv_lin, r_cnt, c_cnt, win_valid, map_done
    );
endinterface

// File: rtl/pool_fmap_collect_win_cnt.sv
// pool_win_cnt: pooling-window row/column counter over a POOL_DIM x POOL_DIM grid.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous return to (0,0), dominates step
//   step     : advance one window, column first, wrapping (last,last) -> (0,0)
//   r_cnt    : window row
//   c_cnt    : window column
//   at_last  : counter sits on the final window of the grid
module pool_win_cnt
    import pool_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    output logic [1:0] r_cnt,
    output logic [1:0] c_cnt,
    output logic       at_last
);

    localparam logic [1:0] LAST = 2'(POOL_DIM - 1);

    logic [1:0] r_cnt_r;
    logic [1:0] c_cnt_r;

    // Row/column counters; a wrap from the last window lands back on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_r <= 2'd0;
            c_cnt_r <= 2'd0;
        end else if (clr) begin
            r_cnt_r <= 2'd0;
            c_cnt_r <= 2'd0;
        end else if (step) begin
            if (c_cnt_r == LAST) begin
                c_cnt_r <= 2'd0;
                r_cnt_r <= (r_cnt_r == LAST) ? 2'd0 : r_cnt_r + 2'd1;
            end else begin
                c_cnt_r <= c_cnt_r + 2'd1;
            end
        end else begin
            r_cnt_r <= r_cnt_r;
            c_cnt_r <= c_cnt_r;
        end
    end

    assign r_cnt   = r_cnt_r;
    assign c_cnt   = c_cnt_r;
    assign at_last = (r_cnt_r == LAST) && (c_cnt_r == LAST);

endmodule

// File: rtl/pool_fmap_collect.sv
// pool_fmap_collect: collects a streamed 6x6 feature map into a flat register
// bus, then sequences the nine 2x2 pooling windows for the max-pool stage.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous abort back to FILL, slot 0 (map contents kept)
//   bus      : pixel stream in, packed map + window counters/handshake out
//   err_last : sticky flag, in_last did not coincide with slot 35
module pool_fmap_collect
    import pool_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    pool_fmap_collect_if.slave    bus,
    output logic                  err_last
);

    localparam logic [5:0] LAST_SLOT = 6'(NUM_PIX - 1);

    state_t              state_r;
    logic [5:0]          wr_ptr_r;
    logic                in_ready_r;
    logic                win_valid_r;
    logic                map_done_r;
    logic                err_last_r;
    logic [DATA_W-1:0]   pix_r [NUM_PIX];
    logic [NUM_PIX-1:0]  wr_en_s;
    logic                accept_s;
    logic                last_slot_s;
    logic                win_step_s;
    logic                cnt_clr_s;
    logic                at_last_s;

    // in_ready_r is only ever set in FILL, so it alone qualifies a pixel accept.
    assign accept_s    = bus.in_valid & in_ready_r;
    assign last_slot_s = (wr_ptr_r == LAST_SLOT);
    assign win_step_s  = win_valid_r & bus.win_ready & ~clr;
    // Counters restart on abort and whenever a new map enters DRAIN.
    assign cnt_clr_s   = clr | (accept_s & last_slot_s);

    pool_win_cnt u_win_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .step    (win_step_s),
        .r_cnt   (bus.r_cnt),
        .c_cnt   (bus.c_cnt),
        .at_last (at_last_s)
    );

    // Slot-write decoder: one enable per map pixel, clr suppresses the write.
    for (genvar gr = 0; gr < MAP_DIM; gr++) begin : g_row
        for (genvar gc = 0; gc < MAP_DIM; gc++) begin : g_col
            localparam logic [5:0] SLOT = idx(3'(gr), 3'(gc));
            assign wr_en_s[SLOT] = accept_s & ~clr & (wr_ptr_r == SLOT);
        end
    end

    // Pixel storage; only FILL writes touch it, so it is frozen during DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIX; i++) begin
                pix_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PIX; i++) begin
                if (wr_en_s[i]) begin
                    pix_r[i] <= bus.in_data;
                end else begin
                    pix_r[i] <= pix_r[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_lin
        assign bus.conv_lin[gi*DATA_W +: DATA_W] = pix_r[gi];
    end

    // Control FSM with registered handshake outputs, write pointer and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILL;
            wr_ptr_r    <= 6'd0;
            in_ready_r  <= 1'b1;
            win_valid_r <= 1'b0;
            map_done_r  <= 1'b0;
            err_last_r  <= 1'b0;
        end else if (clr) begin
            state_r     <= FILL;
            wr_ptr_r    <= 6'd0;
            in_ready_r  <= 1'b1;
            win_valid_r <= 1'b0;
            map_done_r  <= 1'b0;
        end else begin
            map_done_r <= 1'b0;
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        // Marker must appear on slot 35 and nowhere else.
                        if (bus.in_last != last_slot_s) begin
                            err_last_r <= 1'b1;
                        end
                        if (last_slot_s) begin
                            wr_ptr_r    <= 6'd0;
                            state_r     <= DRAIN;
                            in_ready_r  <= 1'b0;
                            win_valid_r <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (win_valid_r && bus.win_ready && at_last_s) begin
                        state_r     <= FILL;
                        in_ready_r  <= 1'b1;
                        win_valid_r <= 1'b0;
                        map_done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= FILL;
                    wr_ptr_r    <= 6'd0;
                    in_ready_r  <= 1'b1;
                    win_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.win_valid = win_valid_r;
    assign bus.map_done  = map_done_r;
    assign err_last      = err_last_r;

endmodule

// File: tb/tb_pool_fmap_collect.sv
module tb_pool_fmap_collect;
    import pool_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic err_last;

    pool_fmap_collect_if bus ();

    pool_fmap_collect dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .bus      (bus),
        .err_last (err_last)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miscompares = 0;
    logic [7:0] model_mem [36];
    bit err_m;

    typedef struct packed {
        logic [1:0]  r;
        logic [1:0]  c;
        logic [31:0] pix;
    } win_t;
    win_t sb[$];

    typedef struct {
        bit rnd;
        int offset;
        int err_pos;
        bit drop35;
        bit bubbles;
        bit bp;
        bit exp_err;
    } map_vec_t;
    map_vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] slot(input int s);
        return bus.conv_lin[s*8 +: 8];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_map(input map_vec_t v);
        int acc = 0;
        int n = 0;
        logic [7:0] d;
        bit lst;
        int b;
        while (acc < 36 && n < 400) begin
            bus.in_valid  = v.bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            d             = v.rnd ? 8'($urandom) : 8'(acc + v.offset);
            lst           = (acc == 35 && !v.drop35) || (acc == v.err_pos);
            bus.in_data   = d;
            bus.in_last   = lst;
            bus.win_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            chk("fill_win_valid", 32'(bus.win_valid), 32'd0);
            chk("fill_err_last", 32'(err_last), 32'(err_m));
            if (bus.in_valid) begin
                model_mem[acc] = d;
                if (lst != (acc == 35)) err_m = 1'b1;
                acc++;
            end
            n++;
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (acc < 36) begin
            vecs++;
            miscompares++;
            $display("FAIL fill_timeout: got %0d accepts required 36", acc);
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                b = (2 * r) * 6 + 2 * c;
                sb.push_back('{r: 2'(r), c: 2'(c),
                               pix: {model_mem[b], model_mem[b+1], model_mem[b+6], model_mem[b+7]}});
            end
        end
    endtask

    task automatic drain_map(input bit bp, input bit exp_err);
        int n = 0;
        int b;
        win_t w;
        // Pixels offered during DRAIN must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        bus.in_last  = 1'b1;
        while (sb.size() > 0 && n < 200) begin
            bus.win_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            w = sb[0];
            b = (2 * int'(w.r)) * 6 + 2 * int'(w.c);
            chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
            chk("drain_win_valid", 32'(bus.win_valid), 32'd1);
            chk("win_rc", 32'({bus.r_cnt, bus.c_cnt}), 32'({w.r, w.c}));
            chk("win_pix", {slot(b), slot(b + 1), slot(b + 6), slot(b + 7)}, w.pix);
            chk("drain_map_done", 32'(bus.map_done), 32'd0);
            chk("drain_err_last", 32'(err_last), 32'(err_m));
            if (bus.win_ready) void'(sb.pop_front());
            if (sb.size() == 0) bus.in_valid = 1'b0;
            n++;
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.win_ready = 1'b0;
        if (sb.size() > 0) begin
            vecs++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d windows left required 0", sb.size());
            sb.delete();
        end else begin
            chk("done_map_done", 32'(bus.map_done), 32'd1);
            chk("done_in_ready", 32'(bus.in_ready), 32'd1);
            chk("done_win_valid", 32'(bus.win_valid), 32'd0);
            chk("done_rc", 32'({bus.r_cnt, bus.c_cnt}), 32'd0);
            chk("done_err_last", 32'(err_last), 32'(exp_err));
            if (!bp) chk("drain_cycles", 32'(n), 32'd9);
        end
        cyc();
        chk("map_done_single", 32'(bus.map_done), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        //            rnd  off  errp drop bub  bp   exp
        tbl[0] = '{1'b0, 0,   -1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 0,   -1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 0,   -1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 100, 20, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 0,   -1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 0,   -1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 200, -1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.win_ready = 1'b0;
        err_m         = 1'b0;
        for (int i = 0; i < 36; i++) model_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_win_valid", 32'(bus.win_valid), 32'd0);
        chk("rst_map_done", 32'(bus.map_done), 32'd0);
        chk("rst_err_last", 32'(err_last), 32'd0);
        chk("rst_rc", 32'({bus.r_cnt, bus.c_cnt}), 32'd0);
        chk("rst_conv_lin", 32'(|bus.conv_lin), 32'd0);

        // Reset mid-stream after 10 pixels
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'hA0 + i);
            bus.in_last  = 1'b0;
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("prefill_slot9", 32'(slot(9)), 32'h0A9);
        chk("prefill_slot0", 32'(slot(0)), 32'h0A0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) chk("midrst_slot", 32'(slot(i)), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_win_valid", 32'(bus.win_valid), 32'd0);

        // Table of full maps
        for (int i = 0; i < 5; i++) begin
            fill_map(tbl[i]);
            drain_map(tbl[i].bp, tbl[i].exp_err);
        end

        // clr during DRAIN on window (1,0)
        fill_map(tbl[5]);
        bus.win_ready = 1'b1;
        repeat (3) cyc();
        chk("preclr_rc", 32'({bus.r_cnt, bus.c_cnt}), 32'({2'd1, 2'd0}));
        clr = 1'b1;
        cyc();
        clr           = 1'b0;
        bus.win_ready = 1'b0;
        chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("clr_win_valid", 32'(bus.win_valid), 32'd0);
        chk("clr_rc", 32'({bus.r_cnt, bus.c_cnt}), 32'd0);
        chk("clr_map_done", 32'(bus.map_done), 32'd0);
        chk("clr_err_last", 32'(err_last), 32'd1);
        cyc();
        chk("clr_map_done2", 32'(bus.map_done), 32'd0);
        sb.delete();
        fill_map(tbl[6]);
        drain_map(tbl[6].bp, tbl[6].exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
